// File: rtl/rom_bus_if.sv
// ROM-side bus interface for a 4-bit CPU: address capture, fetch drive over M1/M2,
// SRC/WRR/RDR handling of the 4-bit I/O port.
module rom_bus_if #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        sync,
  input  logic        cm_rom,
  input  logic [3:0]  d_in,
  output logic [3:0]  d_out,
  output logic        d_oe,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic [3:0]  io_in,
  output logic [3:0]  io_out
);

  typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} state_t;

  localparam logic [7:0] OP_WRR = 8'hE0;
  localparam logic [7:0] OP_RDR = 8'hEA;

  state_t      state, nxt;
  logic        sel, io_sel;
  logic [3:0]  addr_lo, addr_mid;
  logic [7:0]  opcode;
  logic        d_oe_q;
  logic [3:0]  d_out_q;
  logic        sel_nxt, drv_nxt, is_src, rdr_drv;
  logic [3:0]  dout_nxt;

  always_comb begin
    nxt = state;
    if (step) begin
      if (sync) nxt = A1;
      else begin
        case (state)
          A1:      nxt = A2;
          A2:      nxt = A3;
          A3:      nxt = M1;
          M1:      nxt = M2;
          M2:      nxt = X1;
          X1:      nxt = X2;
          X2:      nxt = X3;
          default: nxt = IDLE;
        endcase
      end
    end
  end

  // Output registers are decoded from the next state; they reload every clk so
  // the fetch nibble follows rom_data once it settles after the A3 address update.
  always_comb begin
    sel_nxt  = (step && state == A3) ? (cm_rom && d_in == CHIP_ID) : sel;
    drv_nxt  = sel_nxt && (nxt == M1 || nxt == M2);
    dout_nxt = 4'h0;
    if (drv_nxt) dout_nxt = (nxt == M1) ? rom_data[7:4] : rom_data[3:0];
  end

  assign is_src  = (opcode[7:4] == 4'h2) && opcode[0];
  assign rdr_drv = (state == X2) && (opcode == OP_RDR) && io_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      io_sel   <= 1'b0;
      addr_lo  <= 4'h0;
      addr_mid <= 4'h0;
      rom_addr <= 12'h000;
      opcode   <= 8'h00;
      io_out   <= 4'h0;
      d_oe_q   <= 1'b0;
      d_out_q  <= 4'h0;
    end else begin
      state   <= nxt;
      sel     <= sel_nxt;
      d_oe_q  <= drv_nxt;
      d_out_q <= dout_nxt;
      if (step) begin
        case (state)
          A1: addr_lo  <= d_in;
          A2: addr_mid <= d_in;
          A3: rom_addr <= {d_in, addr_mid, addr_lo};
          // When selected, the bus carries our own ROM nibble, i.e. rom_data.
          M1: opcode[7:4] <= sel ? rom_data[7:4] : d_in;
          M2: opcode[3:0] <= sel ? rom_data[3:0] : d_in;
          X2: begin
            if (is_src && cm_rom) io_sel <= (d_in == CHIP_ID);
            if (opcode == OP_WRR && io_sel) io_out <= d_in;
          end
          default: ;
        endcase
      end
    end
  end

  assign d_oe  = d_oe_q | rdr_drv;
  assign d_out = rdr_drv ? io_in : d_out_q;

endmodule

// File: tb/tb_rom_bus_if.sv
// Self-checking bench for rom_bus_if: transaction-level model of fetch and I/O port behaviour.
module tb_rom_bus_if;
  localparam logic [3:0] CHIP = 4'h0;

  logic        clk = 1'b0;
  logic        rst_n, step, sync, cm_rom;
  logic [3:0]  d_in, d_out, io_in, io_out;
  logic        d_oe;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  rom [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  // transaction-level model state
  logic       m_io_sel = 1'b0;
  logic [3:0] m_io_out = 4'h0;

  rom_bus_if #(.CHIP_ID(CHIP)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .sync(sync), .cm_rom(cm_rom),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .rom_addr(rom_addr),
    .rom_data(rom_data), .io_in(io_in), .io_out(io_out)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic do_step(input logic s, input logic cm, input logic [3:0] d);
    @(negedge clk);
    sync = s; cm_rom = cm; d_in = d; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Drives one full instruction cycle; samples after each subcycle entry (A1..X3).
  task automatic run_cycle(input logic [11:0] addr, input logic cm, input logic [7:0] bus_op,
                           input logic [3:0] x2_d, input logic x2_cm,
                           output logic [7:0] oe_o, output logic [7:0][3:0] dout_o,
                           output logic [11:0] addr_o);
    do_step(1'b1, 1'b0, 4'h0);       oe_o[0] = d_oe; dout_o[0] = d_out;
    do_step(1'b0, 1'b0, addr[3:0]);  oe_o[1] = d_oe; dout_o[1] = d_out;
    do_step(1'b0, 1'b0, addr[7:4]);  oe_o[2] = d_oe; dout_o[2] = d_out;
    do_step(1'b0, cm, addr[11:8]);   oe_o[3] = d_oe; dout_o[3] = d_out; addr_o = rom_addr;
    do_step(1'b0, 1'b0, bus_op[7:4]); oe_o[4] = d_oe; dout_o[4] = d_out;
    do_step(1'b0, 1'b0, bus_op[3:0]); oe_o[5] = d_oe; dout_o[5] = d_out;
    do_step(1'b0, 1'b0, 4'h0);       oe_o[6] = d_oe; dout_o[6] = d_out;
    do_step(1'b0, x2_cm, x2_d);      oe_o[7] = d_oe; dout_o[7] = d_out;
  endtask

  // Expected bus behaviour of one instruction cycle, from the functional rules.
  task automatic model_cycle(input logic [11:0] addr, input logic cm, input logic [7:0] bus_op,
                             input logic [3:0] x2_d, input logic x2_cm,
                             output logic [7:0] exp_oe, output logic [7:0][3:0] exp_dout);
    logic       sel;
    logic [7:0] op;
    sel      = cm && (addr[11:8] == CHIP);
    op       = sel ? rom[addr] : bus_op;
    exp_oe   = '0;
    exp_dout = '0;
    if (sel) begin
      exp_oe[3] = 1'b1; exp_dout[3] = rom[addr][7:4];
      exp_oe[4] = 1'b1; exp_dout[4] = rom[addr][3:0];
    end
    if (op == 8'hEA && m_io_sel) begin
      exp_oe[6] = 1'b1; exp_dout[6] = io_in;
    end
    if (op == 8'hE0 && m_io_sel) m_io_out = x2_d;
    if (op[7:4] == 4'h2 && op[0] && x2_cm) m_io_sel = (x2_d == CHIP);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; step = 0; sync = 0; cm_rom = 0; d_in = 0; io_in = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL reset_doe: got %b expected 0", d_oe); end
    n_checks++; if (d_out !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", d_out); end
    n_checks++; if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h expected 000", rom_addr); end
    n_checks++; if (io_out !== 4'h0) begin n_fail++; $display("FAIL reset_io: got %h expected 0", io_out); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_step(1'b0, 1'b0, 4'h0);
      n_checks++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL idle_doe[%0d]: got %b expected 0", i, d_oe); end
    end
    n_checks++; if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL idle_addr: got %h expected 000", rom_addr); end
  endtask

  task automatic test_fetch(input string name, input logic [11:0] addr, input logic [7:0] bus_op,
                            input logic [3:0] x2_d, input logic x2_cm);
    logic [7:0] oe_o, exp_oe;
    logic [7:0][3:0] dout_o, exp_dout;
    logic [11:0] addr_o;
    model_cycle(addr, 1'b1, bus_op, x2_d, x2_cm, exp_oe, exp_dout);
    run_cycle(addr, 1'b1, bus_op, x2_d, x2_cm, oe_o, dout_o, addr_o);
    n_checks++; if (addr_o !== addr) begin n_fail++; $display("FAIL %s_addr: got %h expected %h", name, addr_o, addr); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (oe_o[i] !== exp_oe[i]) begin n_fail++; $display("FAIL %s_doe[%0d]: got %b expected %b", name, i, oe_o[i], exp_oe[i]); end
      n_checks++; if (dout_o[i] !== exp_dout[i]) begin n_fail++; $display("FAIL %s_dout[%0d]: got %h expected %h", name, i, dout_o[i], exp_dout[i]); end
    end
    n_checks++; if (io_out !== m_io_out) begin n_fail++; $display("FAIL %s_io: got %h expected %h", name, io_out, m_io_out); end
  endtask

  task automatic test_io_port;
    rom[12'h010] = 8'h21; rom[12'h011] = 8'hE0; rom[12'h012] = 8'hEA;
    io_in = 4'h6;
    test_fetch("src_hit", 12'h010, 8'h00, 4'h0, 1'b1);
    test_fetch("wrr_hit", 12'h011, 8'h00, 4'h9, 1'b0);
    n_checks++; if (io_out !== 4'h9) begin n_fail++; $display("FAIL wrr_value: got %h expected 9", io_out); end
    test_fetch("rdr_hit", 12'h012, 8'h00, 4'h0, 1'b0);
    test_fetch("src_miss", 12'h010, 8'h00, 4'h3, 1'b1);
    test_fetch("wrr_miss", 12'h011, 8'h00, 4'h5, 1'b0);
    n_checks++; if (io_out !== 4'h9) begin n_fail++; $display("FAIL wrr_hold: got %h expected 9", io_out); end
    test_fetch("rdr_miss", 12'h012, 8'h00, 4'h0, 1'b0);
    // unselected fetch: opcode comes from the bus (SRC 21), then RDR from our ROM
    test_fetch("src_bus", 12'h134, 8'h21, 4'h0, 1'b1);
    io_in = 4'hC;
    test_fetch("rdr_after_bus", 12'h012, 8'h00, 4'h0, 1'b0);
  endtask

  task automatic test_random;
    logic [11:0] addr;
    logic [7:0]  op;
    for (int n = 0; n < 30; n++) begin
      addr = 12'($urandom);
      if ($urandom_range(0, 1) == 0) addr[11:8] = CHIP;
      case ($urandom_range(0, 3))
        0: op = 8'h21 | 8'($urandom_range(0, 1) << 1);
        1: op = 8'hE0;
        2: op = 8'hEA;
        default: op = 8'($urandom);
      endcase
      io_in = 4'($urandom);
      begin
        logic [7:0] oe_o, exp_oe;
        logic [7:0][3:0] dout_o, exp_dout;
        logic [11:0] addr_o;
        logic cm, xcm;
        logic [3:0] xd;
        cm  = 1'($urandom);
        xcm = 1'($urandom);
        xd  = ($urandom_range(0, 1) == 0) ? CHIP : 4'($urandom);
        model_cycle(addr, cm, op, xd, xcm, exp_oe, exp_dout);
        run_cycle(addr, cm, op, xd, xcm, oe_o, dout_o, addr_o);
        n_checks++; if (addr_o !== addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, addr_o, addr); end
        n_checks++; if (oe_o !== exp_oe) begin n_fail++; $display("FAIL rnd_doe[%0d]: got %b expected %b", n, oe_o, exp_oe); end
        n_checks++; if (dout_o !== exp_dout) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h expected %h", n, dout_o, exp_dout); end
        n_checks++; if (io_out !== m_io_out) begin n_fail++; $display("FAIL rnd_io[%0d]: got %h expected %h", n, io_out, m_io_out); end
      end
    end
  endtask

  task automatic test_no_sync;
    for (int i = 0; i < 6; i++) begin
      do_step(1'b0, 1'b1, CHIP);
      n_checks++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL nosync_doe[%0d]: got %b expected 0", i, d_oe); end
    end
  endtask

  task automatic test_reset_mid;
    rom[12'h020] = 8'hE0;
    test_fetch("pre_sel", 12'h010, 8'h00, 4'h0, 1'b1);   // SRC hit
    test_fetch("pre_wrr", 12'h020, 8'h00, 4'h7, 1'b0);   // io_out <= 7
    do_step(1'b1, 1'b0, 4'h0);
    do_step(1'b0, 1'b0, 4'h4);
    do_step(1'b0, 1'b0, 4'h3);
    do_step(1'b0, 1'b1, CHIP);                           // now in M1, selected
    n_checks++; if (d_oe !== 1'b1) begin n_fail++; $display("FAIL mid_m1_doe: got %b expected 1", d_oe); end
    n_checks++; if (io_out !== 4'h7) begin n_fail++; $display("FAIL mid_io_pre: got %h expected 7", io_out); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_doe: got %b expected 0", d_oe); end
    n_checks++; if (d_out !== 4'h0) begin n_fail++; $display("FAIL mid_rst_dout: got %h expected 0", d_out); end
    n_checks++; if (io_out !== 4'h0) begin n_fail++; $display("FAIL mid_rst_io: got %h expected 0", io_out); end
    n_checks++; if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL mid_rst_addr: got %h expected 000", rom_addr); end
    m_io_sel = 1'b0; m_io_out = 4'h0;
    @(negedge clk); rst_n = 1'b1;
    // after reset, a step without a fresh address phase must not drive
    do_step(1'b0, 1'b1, CHIP);
    n_checks++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL post_rst_doe: got %b expected 0", d_oe); end
    io_in = 4'h2;
    test_fetch("post_rdr", 12'h012, 8'h00, 4'h0, 1'b0); // io_sel cleared: no drive
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h034] = 8'hA5;
    test_reset;
    test_fetch("fetch_sel", 12'h034, 8'h00, 4'h0, 1'b0);
    test_fetch("fetch_unsel", 12'h134, 8'h5C, 4'h0, 1'b0);
    test_io_port;
    test_random;
    test_no_sync;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_bus_if.md
ROM_BUS_IF -- requirements
Module: rom_bus_if

Interface
REQ-001 The module SHALL have parameter CHIP_ID, default 4'h0, giving the 4-bit ROM chip number this block answers to.
REQ-002 The module SHALL have port clk, input, 1 bit: system clock, the same clock that runs the CPU core.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port step, input, 1 bit: one-clk pulse per CPU bus subcycle, marking the sampling edge.
REQ-005 The module SHALL have port sync, input, 1 bit: CPU SYNC, high during the X3 subcycle.
REQ-006 The module SHALL have port cm_rom, input, 1 bit: CPU CM-ROM strobe.
REQ-007 The module SHALL have port d_in, input, 4 bits: data bus nibble driven by the CPU.
REQ-008 The module SHALL have port d_out, output, 4 bits: nibble this block drives onto the bus.
REQ-009 The module SHALL have port d_oe, output, 1 bit: high while d_out is valid and driven.
REQ-010 The module SHALL have port rom_addr, output, 12 bits: fetch address presented to the external ROM array.
REQ-011 The module SHALL have port rom_data, input, 8 bits: combinational byte at rom_addr, stable from the step after rom_addr changes.
REQ-012 The module SHALL have port io_in, input, 4 bits: ROM I/O port input pins.
REQ-013 The module SHALL have port io_out, output, 4 bits: ROM I/O port output latch.

Function
REQ-014 The block SHALL sequence through the states IDLE, A1, A2, A3, M1, M2, X1, X2, X3, advancing only on clk edges where step=1.
REQ-015 On step with sync=1, from any state including IDLE, the next state SHALL be A1.
REQ-016 On step with sync=0, the state SHALL advance in order A1→A2→A3→M1→M2→X1→X2→X3; X3→IDLE; IDLE stays in IDLE.
REQ-017 The A1, A2 and A3 steps SHALL capture d_in into address bits [3:0], [7:4] and [11:8] respectively.
REQ-018 rom_addr SHALL update once, with all 12 bits, at the A3 step.
REQ-019 The A3 step SHALL set sel = cm_rom && (d_in == CHIP_ID); at any other A3, sel SHALL clear.
REQ-020 In M1 with sel=1: d_oe=1 and d_out=rom_data[7:4].
REQ-021 In M2 with sel=1: d_oe=1 and d_out=rom_data[3:0].
REQ-022 The opcode latch SHALL capture OPR at the M1 step and OPA at the M2 step, taken from d_out when sel=1 and from d_in otherwise.
REQ-023 SRC is OPR=4'h2 with OPA[0]=1; on the X2 step of an SRC cycle with cm_rom=1, io_sel SHALL be set to (d_in == CHIP_ID).
REQ-024 io_sel SHALL hold its value until the next SRC X2 step.
REQ-025 WRR is opcode 8'hE0; on its X2 step, if io_sel=1, io_out SHALL load d_in.
REQ-026 RDR is opcode 8'hEA; during its X2 state, if io_sel=1, the block SHALL drive d_oe=1 and d_out=io_in.
REQ-027 In all other states and conditions, d_oe SHALL be 0 and d_out SHALL be 4'h0.
REQ-028 d_oe and d_out SHALL be registered state decodes, changing only on clk edges, except the RDR case, which passes io_in through combinationally.
REQ-029 Consecutive instruction cycles with no IDLE gap SHALL be supported: sync at X3 leads directly to A1.
REQ-030 step=0 SHALL freeze all state indefinitely.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE; sel=0; io_sel=0; rom_addr=12'h000; opcode latch=8'h00; io_out=4'h0; d_out=4'h0; d_oe=0.
REQ-032 Reset asserted mid-cycle, including during M1/M2 drive, SHALL drop d_oe immediately, without waiting for a clk edge.
REQ-033 After reset release, the block SHALL drive nothing until a step with sync=1 is followed by a full A1–A3 address phase.

Verification
- Reset with all inputs at 0 -> every output at 0; state IDLE after 20 steps with sync low.
- CHIP_ID=0; A1=4, A2=3, A3=0 with cm_rom=1; rom_data=8'hA5 -> rom_addr=12'h034; d_oe=1 with d_out=4'hA in M1 and 4'h5 in M2; d_oe=0 in every other subcycle.
- Same sequence but A3=1 -> sel=0; d_oe stays 0 for the whole cycle; opcode taken from d_in.
- SRC byte 8'h21, X2 d_in=0 with cm_rom=1 -> io_sel=1; next cycle WRR 8'hE0 with X2 d_in=9 -> io_out=4'h9; then RDR 8'hEA with io_in=6 -> d_out=4'h6, d_oe=1 during X2.
- SRC with X2 d_in=3 -> io_sel=0; a following WRR leaves io_out unchanged; RDR drives nothing.
- Sync missing at X3 -> IDLE, no drive; rst_n pulsed low during M1 -> d_oe falls the same cycle and io_out=0.
